// File: rtl/pulse_indicator_driver_pkg.sv
// Shared constants for the LED pulse indicator: state encoding, tick
// divider ratios and counter widths.
package pulse_indicator_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // clk cycles per tick: 1 ms at 100 MHz on hardware, short in simulation
  localparam int DIV_HW  = 100000;
  localparam int DIV_SIM = 4;

  localparam int TICK_W = 8;   // holds up to 255 ticks per phase
  localparam int PRE_W  = 17;  // holds DIV_HW-1

endpackage

// File: rtl/pulse_indicator_driver_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks. clr restarts the
// count so a phase that begins on a state change gets whole ticks only.
module tick_gen
  import pulse_indicator_driver_pkg::*;
#(
  parameter int sim = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int DIV = (sim != 0) ? DIV_SIM : DIV_HW;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = (pre == PRE_LAST);

  // count 0..DIV-1, wrap on the tick, restart on clear or reset
  always_ff @(posedge clk) begin
    if (!reset || clr || tick) pre <= '0;
    else                       pre <= pre + 1'b1;
  end

endmodule

// File: rtl/pulse_indicator_driver.sv
// Turns single-cycle event strobes into fixed-length LED blinks separated
// by a fixed dark gap. Strobes arriving while a blink or gap is in progress
// are queued in a saturating counter and replayed one blink each.
module pulse_indicator_driver
  import pulse_indicator_driver_pkg::*;
#(
  parameter int sim       = 0,
  parameter int ON_TICKS  = 200,
  parameter int GAP_TICKS = 100,
  parameter int MAX_PEND  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PulseIn,
  output logic       LedOut,
  output logic       Busy,
  output logic [2:0] Pending,
  output logic       Dropped
);

  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);
  localparam logic [2:0]        PEND_MAX = 3'(MAX_PEND);

  state_t            state, state_nxt;
  logic [2:0]        pend_nxt;
  logic              drop_nxt;
  logic              clr;
  logic              tick;
  logic [TICK_W-1:0] tcnt;

  tick_gen #(.sim(sim)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  // ticks elapsed in the current phase; restarts with every state change
  always_ff @(posedge clk) begin
    if (!reset || clr) tcnt <= '0;
    else if (tick)     tcnt <= tcnt + 1'b1;
  end

  // next state, queue update and drop strobe
  always_comb begin
    state_nxt = state;
    pend_nxt  = Pending;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // a strobe from idle is shown directly, never queued
        if (PulseIn) state_nxt = ON;
      end
      ON: begin
        if (PulseIn) begin
          if (Pending == PEND_MAX) drop_nxt = 1'b1;
          else                     pend_nxt = Pending + 3'd1;
        end
        if (tick && tcnt == ON_LAST) state_nxt = GAP;
      end
      GAP: begin
        if (tick && tcnt == GAP_LAST) begin
          // end of gap: a queued event or a strobe right now starts the
          // next blink; a strobe here replaces the dequeue (net zero)
          if (Pending != 3'd0 || PulseIn) begin
            state_nxt = ON;
            if (Pending != 3'd0 && !PulseIn) pend_nxt = Pending - 3'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (PulseIn) begin
          if (Pending == PEND_MAX) drop_nxt = 1'b1;
          else                     pend_nxt = Pending + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    clr = (state_nxt != state);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      LedOut  <= 1'b0;
      Busy    <= 1'b0;
      Pending <= 3'd0;
      Dropped <= 1'b0;
    end else begin
      state   <= state_nxt;
      LedOut  <= (state_nxt == ON);
      Busy    <= (state_nxt != IDLE);
      Pending <= pend_nxt;
      Dropped <= drop_nxt;
    end
  end

endmodule
